// File: rtl/conv_input_buffer.sv
// conv_input_buffer: double-buffered activation line buffer feeding the 12-PE MMU.
// The controller fills the shadow bank one 32-bit word per cycle. A swap strobe
// exposes the shadow bank to the MMU in parallel and reports whether it was fully
// loaded.
module conv_input_buffer #(
  parameter int N_PE   = 12,
  parameter int N_WIN  = 7,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ibuf_load_en,
  input  logic [3:0]                    ibuf_load_pe_idx,
  input  logic [2:0]                    ibuf_load_win_idx,
  input  logic [DATA_W-1:0]             ibuf_load_data,
  input  logic                          ibuf_swap,
  output logic [N_PE*N_WIN*DATA_W-1:0]  act_data,
  output logic                          act_valid,
  output logic [6:0]                    fill_count,
  output logic                          shadow_full,
  output logic                          swap_incomplete,
  output logic                          load_err
);

  localparam int N_WORDS = N_PE * N_WIN;

  logic               bank_sel_reg;
  logic [N_WORDS-1:0] mask_reg;
  logic [N_WORDS-1:0] mask_next;
  logic [6:0]         fill_count_reg;
  logic [6:0]         fill_count_next;
  logic               act_valid_reg;
  logic               swap_incomplete_reg;
  logic               load_err_reg;

  logic               load_in_range;
  logic               load_hit;
  logic [6:0]         load_addr;
  logic [N_WORDS-1:0] load_bit;
  logic               load_is_new;
  logic               shadow_complete;

  // Decode the load request into a one-hot word select; out-of-range requests select nothing.
  always_comb begin
    load_in_range   = (int'(ibuf_load_pe_idx) < N_PE) && (int'(ibuf_load_win_idx) < N_WIN);
    load_hit        = ibuf_load_en && load_in_range;
    load_addr       = 7'(ibuf_load_pe_idx) * 7'(N_WIN) + 7'(ibuf_load_win_idx);
    load_bit        = load_hit ? (N_WORDS'(1) << load_addr) : '0;
    load_is_new     = load_hit && ((mask_reg & load_bit) == '0);
    // A load in the swap cycle lands in the outgoing shadow bank, so it counts here.
    shadow_complete = &(mask_reg | load_bit);
    if (ibuf_swap) begin
      mask_next       = '0;
      fill_count_next = '0;
    end else begin
      mask_next       = mask_reg | load_bit;
      fill_count_next = fill_count_reg + {6'd0, load_is_new};
    end
  end

  // Bank select, fill tracking and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel_reg        <= 1'b0;
      mask_reg            <= '0;
      fill_count_reg      <= '0;
      act_valid_reg       <= 1'b0;
      swap_incomplete_reg <= 1'b0;
      load_err_reg        <= 1'b0;
    end else begin
      mask_reg            <= mask_next;
      fill_count_reg      <= fill_count_next;
      swap_incomplete_reg <= ibuf_swap && !shadow_complete;
      load_err_reg        <= ibuf_load_en && !load_in_range;
      if (ibuf_swap) begin
        bank_sel_reg  <= ~bank_sel_reg;
        act_valid_reg <= shadow_complete;
      end
    end
  end

  // One word slot per (pe, win) in each bank; only the shadow copy is ever written.
  genvar gi;
  generate
    for (gi = 0; gi < N_WORDS; gi++) begin : g_word
      logic [DATA_W-1:0] bank0_reg;
      logic [DATA_W-1:0] bank1_reg;

      // Store the load word into whichever bank is currently the shadow.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bank0_reg <= '0;
          bank1_reg <= '0;
        end else if (load_bit[gi]) begin
          if (bank_sel_reg) bank0_reg <= ibuf_load_data;
          else              bank1_reg <= ibuf_load_data;
        end
      end

      assign act_data[gi*DATA_W +: DATA_W] = bank_sel_reg ? bank1_reg : bank0_reg;
    end
  endgenerate

  assign act_valid       = act_valid_reg;
  assign fill_count      = fill_count_reg;
  assign shadow_full     = (fill_count_reg == 7'(N_WORDS));
  assign swap_incomplete = swap_incomplete_reg;
  assign load_err        = load_err_reg;

endmodule
